// File: rtl/regfile_arb_pkg.sv
// Shared types for the register-file port arbiter: requester ids, read tag
// and the round-robin successor function.
package regfile_arb_pkg;

  localparam int NUM_REQ = 3;

  typedef enum logic [1:0] {
    REQ_W = 2'd0,
    REQ_A = 2'd1,
    REQ_B = 2'd2
  } requester_t;

  typedef struct packed {
    logic       valid;
    requester_t id;
    logic       zero;
  } rd_tag_t;

  // Successor in the W -> A -> B -> W ring; an illegal code restarts at W.
  function automatic requester_t next_req(input requester_t cur);
    case (cur)
      REQ_W:   next_req = REQ_A;
      REQ_A:   next_req = REQ_B;
      REQ_B:   next_req = REQ_W;
      default: next_req = REQ_W;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational three-way round-robin arbiter: one-hot grant plus the
// pointer value to register after this cycle.
module rr_arbiter3
  import regfile_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  requester_t         ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output requester_t         ptr_nxt_o
);

  requester_t c0_s;
  requester_t c1_s;
  requester_t c2_s;

  // Candidate order starting at the highest-priority requester.
  always_comb begin
    c0_s = ((ptr_i == REQ_A) || (ptr_i == REQ_B)) ? ptr_i : REQ_W;
    c1_s = next_req(c0_s);
    c2_s = next_req(c1_s);
  end

  // First requesting candidate wins; the pointer moves past the winner.
  always_comb begin
    gnt_o     = '0;
    ptr_nxt_o = c0_s;
    if (req_i[c0_s]) begin
      gnt_o[c0_s] = 1'b1;
      ptr_nxt_o   = c1_s;
    end else if (req_i[c1_s]) begin
      gnt_o[c1_s] = 1'b1;
      ptr_nxt_o   = c2_s;
    end else if (req_i[c2_s]) begin
      gnt_o[c2_s] = 1'b1;
      ptr_nxt_o   = c0_s;
    end else begin
      gnt_o     = '0;
      ptr_nxt_o = c0_s;
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares one single-port synchronous-read register file between a writer (W)
// and two readers (A, B), returning read data with a valid pulse and hold.
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_req,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [WIDTH-1:0]  w_data,
  output logic              w_gnt,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [WIDTH-1:0]  a_rdata,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [WIDTH-1:0]  b_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_data,
  output logic              ram_wren,
  input  logic [WIDTH-1:0]  ram_q
);

  function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
    is_zero = (ZERO_REG != 0) && (addr == '0);
  endfunction

  requester_t         ptr_q;
  requester_t         ptr_d;
  rd_tag_t            tag_q;
  rd_tag_t            tag_d;
  logic [WIDTH-1:0]   hold_a_q;
  logic [WIDTH-1:0]   hold_b_q;
  logic [WIDTH-1:0]   rd_val_s;
  logic [NUM_REQ-1:0] req_s;
  logic [NUM_REQ-1:0] arb_gnt_s;
  logic [NUM_REQ-1:0] gnt_s;

  assign req_s = {b_req, a_req, w_req};

  rr_arbiter3 u_arb (
    .req_i     (req_s),
    .ptr_i     (ptr_q),
    .gnt_o     (arb_gnt_s),
    .ptr_nxt_o (ptr_d)
  );

  assign gnt_s = reset ? '0 : arb_gnt_s;
  assign w_gnt = gnt_s[REQ_W];
  assign a_gnt = gnt_s[REQ_A];
  assign b_gnt = gnt_s[REQ_B];

  // RAM drive for the granted requester and the tag for the return cycle.
  always_comb begin
    ram_addr = '0;
    ram_data = '0;
    ram_wren = 1'b0;
    tag_d    = '0;
    if (gnt_s[REQ_W]) begin
      ram_addr = w_addr;
      ram_data = w_data;
      ram_wren = !is_zero(w_addr);
    end else if (gnt_s[REQ_A]) begin
      ram_addr    = a_addr;
      tag_d.valid = 1'b1;
      tag_d.id    = REQ_A;
      tag_d.zero  = is_zero(a_addr);
    end else if (gnt_s[REQ_B]) begin
      ram_addr    = b_addr;
      tag_d.valid = 1'b1;
      tag_d.id    = REQ_B;
      tag_d.zero  = is_zero(b_addr);
    end else begin
      tag_d = '0;
    end
  end

  // Reset in the return cycle kills the in-flight read.
  assign rd_val_s = tag_q.zero ? '0 : ram_q;
  assign a_rvalid = tag_q.valid && (tag_q.id == REQ_A) && !reset;
  assign b_rvalid = tag_q.valid && (tag_q.id == REQ_B) && !reset;
  assign a_rdata  = a_rvalid ? rd_val_s : hold_a_q;
  assign b_rdata  = b_rvalid ? rd_val_s : hold_b_q;

  // Pointer, read tag and per-port hold registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= REQ_W;
      tag_q    <= '0;
      hold_a_q <= '0;
      hold_b_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      tag_q <= tag_d;
      if (a_rvalid) hold_a_q <= rd_val_s;
      if (b_rvalid) hold_b_q <= rd_val_s;
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural RAM and a
// queue-based scoreboard for read returns on ports A and B.
module tb_regfile_port_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       w_req, a_req, b_req;
  logic [2:0] w_addr, a_addr, b_addr;
  logic [7:0] w_data;
  logic       w_gnt, a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic [2:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_wren;
  logic [7:0] ram_q;
  logic [7:0] mem [8];

  int n_chk  = 0;
  int n_fail = 0;
  int first_b;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  regfile_port_arbiter #(.WIDTH(8), .ADDR_W(3), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset),
    .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_gnt(w_gnt),
    .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_addr(b_addr), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Single-port RAM, 1-cycle read, new data on read-during-write; addr 0 preset non-zero.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
      mem[0] <= 8'h5A;
      ram_q  <= 8'h00;
    end else begin
      if (ram_wren) mem[ram_addr] <= ram_data;
      ram_q <= ram_wren ? ram_data : mem[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (a_rvalid) begin
      if (exp_a.size() == 0) chk("a_unexpected_rvalid", 32'(a_rvalid), 32'h0);
      else chk("a_rdata", 32'(a_rdata), 32'(exp_a.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (b_rvalid) begin
      if (exp_b.size() == 0) chk("b_unexpected_rvalid", 32'(b_rvalid), 32'h0);
      else chk("b_rdata", 32'(b_rdata), 32'(exp_b.pop_front()));
    end
  end

  initial begin
    reset = 1'b1; w_req = 1'b1; w_addr = 3'd0; w_data = 8'h00;
    a_req = 1'b0; a_addr = 3'd0; b_req = 1'b0; b_addr = 3'd0;
    tick();
    smp();
    chk("rst_w_gnt", 32'(w_gnt), 32'h0);
    chk("rst_wren", 32'(ram_wren), 32'h0);
    chk("rst_a_rvalid", 32'(a_rvalid), 32'h0);
    chk("rst_b_rvalid", 32'(b_rvalid), 32'h0);
    chk("rst_a_rdata", 32'(a_rdata), 32'h0);
    chk("rst_b_rdata", 32'(b_rdata), 32'h0);

    // Write A5 to reg 3, then read it back on A.
    tick(); reset = 1'b0; w_addr = 3'd3; w_data = 8'hA5;
    smp();
    chk("wr_w_gnt", 32'(w_gnt), 32'h1);
    chk("wr_others", 32'({a_gnt, b_gnt}), 32'h0);
    chk("wr_wren", 32'(ram_wren), 32'h1);
    chk("wr_addr", 32'(ram_addr), 32'h3);
    chk("wr_data", 32'(ram_data), 32'hA5);
    tick(); w_req = 1'b0; a_req = 1'b1; a_addr = 3'd3;
    smp();
    chk("rd_a_gnt", 32'(a_gnt), 32'h1);
    chk("rd_wren", 32'(ram_wren), 32'h0);
    chk("rd_addr", 32'(ram_addr), 32'h3);
    exp_a.push_back(8'hA5);
    tick(); a_req = 1'b0;
    smp();
    chk("ret_a_rvalid", 32'(a_rvalid), 32'h1);
    chk("idle_ram", 32'({ram_addr, ram_data, ram_wren}), 32'h0);
    tick();
    smp();
    chk("hold_a_rvalid", 32'(a_rvalid), 32'h0);
    chk("hold_a_rdata", 32'(a_rdata), 32'hA5);

    // All three requesting from reset: W, A, B, W, A, B with read-after-write on reg 5.
    tick(); reset = 1'b1;
    tick(); reset = 1'b0; w_req = 1'b1; a_req = 1'b1; b_req = 1'b1;
    w_addr = 3'd5; a_addr = 3'd5; b_addr = 3'd5; w_data = 8'h30;
    for (int k = 0; k < 6; k++) begin
      smp();
      chk("rr_w_gnt", 32'(w_gnt), 32'(k % 3 == 0));
      chk("rr_a_gnt", 32'(a_gnt), 32'(k % 3 == 1));
      chk("rr_b_gnt", 32'(b_gnt), 32'(k % 3 == 2));
      chk("rr_a_rvalid", 32'(a_rvalid), 32'(k % 3 == 2));
      chk("rr_b_rvalid", 32'(b_rvalid), 32'((k % 3 == 0) && (k > 0)));
      if (k % 3 == 1) exp_a.push_back(8'h30 + 8'(k / 3));
      if (k % 3 == 2) exp_b.push_back(8'h30 + 8'(k / 3));
      tick();
      w_data = 8'h30 + 8'((k + 1) / 3);
    end
    w_req = 1'b0; a_req = 1'b0; b_req = 1'b0;

    // Zero register: write suppressed, read returns 0 rather than the RAM's 5A.
    w_req = 1'b1; w_addr = 3'd0; w_data = 8'hFF;
    smp();
    chk("z_w_gnt", 32'(w_gnt), 32'h1);
    chk("z_wren", 32'(ram_wren), 32'h0);
    tick(); w_req = 1'b0; b_req = 1'b1; b_addr = 3'd0;
    smp();
    chk("z_b_gnt", 32'(b_gnt), 32'h1);
    exp_b.push_back(8'h00);
    tick(); b_req = 1'b0;
    smp();
    chk("z_b_rvalid", 32'(b_rvalid), 32'h1);

    // Reset right after an A grant discards the read and restores the pointer.
    tick(); a_req = 1'b1; a_addr = 3'd3;
    smp();
    chk("mr_a_gnt", 32'(a_gnt), 32'h1);
    tick(); a_req = 1'b0; reset = 1'b1;
    smp();
    chk("mr_rvalid_in_reset", 32'(a_rvalid), 32'h0);
    chk("mr_gnt_in_reset", 32'({w_gnt, a_gnt, b_gnt}), 32'h0);
    tick(); reset = 1'b0;
    smp();
    chk("mr_rvalid_after", 32'(a_rvalid), 32'h0);
    chk("mr_a_rdata", 32'(a_rdata), 32'h0);
    tick(); w_req = 1'b1; a_req = 1'b1; b_req = 1'b1; w_addr = 3'd7; w_data = 8'h77;
    smp();
    chk("mr_ptr_w", 32'({w_gnt, a_gnt, b_gnt}), 32'h4);
    tick(); w_req = 1'b0; a_req = 1'b0; b_req = 1'b0;

    // Alternating A/B reads keep each port's data independent.
    w_req = 1'b1; w_addr = 3'd1; w_data = 8'h11;
    smp();
    chk("alt_w1_gnt", 32'(w_gnt), 32'h1);
    tick(); w_addr = 3'd2; w_data = 8'h22;
    smp();
    chk("alt_w2_gnt", 32'(w_gnt), 32'h1);
    tick(); w_req = 1'b0; a_req = 1'b1; a_addr = 3'd1;
    smp();
    chk("alt_a_gnt", 32'(a_gnt), 32'h1);
    exp_a.push_back(8'h11);
    tick(); a_req = 1'b0; b_req = 1'b1; b_addr = 3'd2;
    smp();
    chk("alt_b_gnt", 32'(b_gnt), 32'h1);
    exp_b.push_back(8'h22);
    tick(); b_req = 1'b0;
    smp();
    chk("alt_a_hold_in_b", 32'(a_rdata), 32'h11);
    chk("alt_a_rvalid_low", 32'(a_rvalid), 32'h0);
    tick();
    smp();
    chk("alt_a_hold_after", 32'(a_rdata), 32'h11);
    chk("alt_b_hold_after", 32'(b_rdata), 32'h22);

    // B held high against continuous W and A traffic.
    tick(); w_req = 1'b1; a_req = 1'b1; b_req = 1'b1;
    w_addr = 3'd6; w_data = 8'h66; a_addr = 3'd6; b_addr = 3'd1;
    first_b = 0;
    for (int c = 1; c <= 3; c++) begin
      smp();
      chk("st_w_gnt", 32'(w_gnt), 32'(c == 1));
      chk("st_a_gnt", 32'(a_gnt), 32'(c == 2));
      if (b_gnt && first_b == 0) first_b = c;
      if (c == 2) exp_a.push_back(8'h66);
      if (c == 3) exp_b.push_back(8'h11);
      tick();
    end
    w_req = 1'b0; a_req = 1'b0; b_req = 1'b0;
    chk("st_b_within_3", 32'((first_b >= 1) && (first_b <= 3)), 32'h1);
    chk("st_b_cycle", 32'(first_b), 32'h3);

    smp();
    tick();
    smp();
    chk("exp_a_drained", 32'(exp_a.size()), 32'h0);
    chk("exp_b_drained", 32'(exp_b.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
